// File: rtl/spi_master_sched.sv
// SPI master sequencer: arbitrates two requesters round-robin and services slave
// interrupts (higher priority) on a single-slave SPI bus. Frames are never preempted.
module spi_master_sched #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    req_rw,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          irq_valid,
  output logic [DW-1:0] irq_addr,
  output logic          sclk,
  output logic          cs,
  output logic          mosi,
  input  logic          miso,
  input  logic          intr_in
);

  localparam int unsigned PerLen = 2 * CLK_DIV;
  localparam int unsigned PhW    = $clog2(PerLen);
  localparam int unsigned BitW   = $clog2(DW);
  localparam logic [PhW-1:0]  PhLast  = PhW'(PerLen - 1);
  localparam logic [PhW-1:0]  PhRise  = PhW'(CLK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(DW - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StOp, StData, StTail, StDone, StIrq, StIrqDone
  } state_e;

  state_e          state_q, state_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   irq_addr_q, irq_addr_d;
  logic            rw_q, rw_d;
  logic            id_q, id_d;
  logic            rr_q, rr_d;
  logic            intr_s1_q, intr_s2_q;
  logic            win, period_end, counting, miso_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ph_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      irq_addr_q <= '0;
      rw_q       <= 1'b0;
      id_q       <= 1'b0;
      rr_q       <= 1'b0;
      intr_s1_q  <= 1'b0;
      intr_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      irq_addr_q <= irq_addr_d;
      rw_q       <= rw_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      intr_s1_q  <= intr_in;
      intr_s2_q  <= intr_s1_q;
    end
  end

  // X/Z on miso falls into the else branch and is stored as 0.
  always_comb begin
    miso_bit = 1'b0;
    if (miso == 1'b1) miso_bit = 1'b1;
  end

  assign counting   = state_q inside {StSetup, StOp, StData, StTail, StIrq};
  assign period_end = (ph_q == PhLast);
  // rr_q names the requester that wins a tie.
  assign win        = (req == 2'b11) ? rr_q : req[1];

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    irq_addr_d = irq_addr_q;
    rw_d       = rw_q;
    id_d       = id_q;
    rr_d       = rr_q;
    gnt        = 2'b00;
    done       = 2'b00;
    irq_valid  = 1'b0;
    ph_d       = (counting && !period_end) ? ph_q + 1'b1 : '0;

    unique case (state_q)
      StIdle: begin
        bit_d = '0;
        if (intr_s2_q) begin
          state_d = StIrq;
        end else if (req != 2'b00) begin
          gnt     = win ? 2'b10 : 2'b01;
          id_d    = win;
          rr_d    = ~win;
          rw_d    = req_rw[win];
          wdata_d = win ? req_wdata1 : req_wdata0;
          shift_d = '0;
          state_d = StSetup;
        end
      end
      StSetup: if (period_end) state_d = StOp;
      StOp:    if (period_end) state_d = StData;
      StData: begin
        if (period_end) begin
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = StTail;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StTail: begin
        if (period_end) begin
          state_d = StDone;
          if (!rw_q) rdata_d = shift_q;
        end
      end
      StDone: begin
        done    = id_q ? 2'b10 : 2'b01;
        state_d = StIdle;
      end
      StIrq: begin
        if (period_end) begin
          if (bit_q == BitLast) begin
            bit_d      = '0;
            irq_addr_d = shift_q;
            state_d    = StIrqDone;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StIrqDone: begin
        irq_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((((state_q == StData) && !rw_q) || (state_q == StIrq)) && (ph_q == PhRise)) begin
      shift_d[bit_q] = miso_bit;
    end
  end

  always_comb begin
    mosi = 1'b0;
    if (state_q == StOp) mosi = rw_q;
    else if (state_q == StData) mosi = rw_q & wdata_q[bit_q];
  end

  assign busy     = (state_q != StIdle);
  assign cs       = state_q inside {StSetup, StOp, StData, StTail};
  assign sclk     = counting && (ph_q >= PhRise);
  assign rdata    = rdata_q;
  assign irq_addr = irq_addr_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Bench for spi_master_sched: directed and random frames against a per-bit-period bus
// model, with a behavioural SPI slave; a CLK_DIV=2 instance covers the fast divider.
module tb_spi_master_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [1:0] req, req_rw;
  logic [7:0] req_wdata0, req_wdata1;
  logic       miso = 1'b0;
  logic       intr_in;

  logic [1:0] gnt_a, done_a, gnt_b, done_b, gnt_m, done_m;
  logic [7:0] rdata_a, irq_addr_a, rdata_b, irq_addr_b, rdata_m, irq_addr_m;
  logic       busy_a, irq_valid_a, sclk_a, cs_a, mosi_a;
  logic       busy_b, irq_valid_b, sclk_b, cs_b, mosi_b;
  logic       busy_m, irq_valid_m, sclk_m, cs_m, mosi_m;

  spi_master_sched #(.CLK_DIV(4), .DW(8)) u_dut_a (
    .clk(clk), .rst(rst_a), .req(req), .req_rw(req_rw), .req_wdata0(req_wdata0),
    .req_wdata1(req_wdata1), .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .busy(busy_a),
    .irq_valid(irq_valid_a), .irq_addr(irq_addr_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a),
    .miso(miso), .intr_in(intr_in)
  );

  spi_master_sched #(.CLK_DIV(2), .DW(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .req(req), .req_rw(req_rw), .req_wdata0(req_wdata0),
    .req_wdata1(req_wdata1), .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .busy(busy_b),
    .irq_valid(irq_valid_b), .irq_addr(irq_addr_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b),
    .miso(miso), .intr_in(intr_in)
  );

  bit sel;
  int cd;

  always_comb begin
    if (sel) begin
      gnt_m = gnt_b; done_m = done_b; rdata_m = rdata_b; irq_addr_m = irq_addr_b;
      busy_m = busy_b; irq_valid_m = irq_valid_b; sclk_m = sclk_b; cs_m = cs_b; mosi_m = mosi_b;
    end else begin
      gnt_m = gnt_a; done_m = done_a; rdata_m = rdata_a; irq_addr_m = irq_addr_a;
      busy_m = busy_a; irq_valid_m = irq_valid_a; sclk_m = sclk_a; cs_m = cs_a; mosi_m = mosi_a;
    end
  end

  int         total = 0;
  int         bad = 0;
  logic       model_rr;
  logic [7:0] model_rdata;
  logic [7:0] s_data, s_irq;

  // Slave: counts sclk falls since the transfer began and presents the next bit
  // mid-cycle, well before the following rising edge.
  int   falls = 0;
  logic busy_p = 1'b0, sclk_p = 1'b0, irq_mode = 1'b0;
  always @(negedge clk) begin
    if (busy_m && !busy_p) begin
      falls    = 0;
      irq_mode = !cs_m;
    end else if (sclk_p && !sclk_m) begin
      falls = falls + 1;
    end
    busy_p = busy_m;
    sclk_p = sclk_m;
    if (!busy_m) miso = 1'b0;
    else if (irq_mode) miso = (falls < 8) ? s_irq[falls] : 1'b0;
    else miso = (falls >= 2 && falls < 10) ? s_data[falls-2] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [1:0] r, input logic [1:0] rw, input logic [7:0] w0,
                       input logic [7:0] w1, input logic [7:0] sd, input bit hold);
    logic        w;
    logic [10:0] bits;
    logic [7:0]  wd;
    int          n, nerr, p, ph;
    req = r; req_rw = rw; req_wdata0 = w0; req_wdata1 = w1; s_data = sd;
    #1;
    n = 0;
    while (gnt_m == 2'b00 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    w = (r == 2'b11) ? model_rr : r[1];
    chk("gnt", 32'(gnt_m), w ? 32'd2 : 32'd1);
    model_rr = ~w;
    wd = w ? w1 : w0;
    bits = '0;
    bits[1] = rw[w];
    for (int i = 0; i < 8; i++) bits[2+i] = rw[w] & wd[i];
    nerr = 0;
    for (int k = 1; k <= 22 * cd; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req = 2'b00;
      p  = (k - 1) / (2 * cd);
      ph = (k - 1) % (2 * cd);
      if (cs_m !== 1'b1 || sclk_m !== (ph >= cd) || mosi_m !== bits[p] ||
          done_m !== 2'b00 || busy_m !== 1'b1 || gnt_m !== 2'b00) nerr++;
    end
    chk("frame_bus", 32'(nerr), 32'd0);
    @(negedge clk);
    chk("done", 32'({done_m, cs_m, sclk_m}), w ? 32'h8 : 32'h4);
    if (!rw[w]) model_rdata = sd;
    chk("rdata", 32'(rdata_m), 32'(model_rdata));
    @(negedge clk);
    chk("idle", 32'({busy_m, cs_m, done_m}), 32'd0);
  endtask

  task automatic irq(input logic [7:0] sa, input bit raise, input logic [1:0] r);
    int   nerr, pulses, ph;
    logic sp;
    s_irq = sa;
    if (raise) begin
      intr_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req = r;
      #1;
      chk("irq_first", 32'(gnt_m), 32'd0);
    end
    intr_in = 1'b0;
    nerr = 0; pulses = 0; sp = 1'b0;
    for (int k = 1; k <= 16 * cd; k++) begin
      @(negedge clk);
      ph = (k - 1) % (2 * cd);
      if (sclk_m && !sp) pulses++;
      sp = sclk_m;
      if (cs_m !== 1'b0 || sclk_m !== (ph >= cd) || mosi_m !== 1'b0 || busy_m !== 1'b1 ||
          irq_valid_m !== 1'b0 || gnt_m !== 2'b00 || done_m !== 2'b00) nerr++;
    end
    chk("irq_bus", 32'(nerr), 32'd0);
    chk("irq_pulses", 32'(pulses), 32'd8);
    @(negedge clk);
    chk("irq_done", 32'({irq_valid_m, irq_addr_m}), 32'({1'b1, sa}));
    @(negedge clk);
    chk("irq_idle", 32'({irq_valid_m, busy_m}), 32'd0);
  endtask

  initial begin
    logic [7:0] wr;
    sel = 1'b0; cd = 4;
    rst_a = 1'b1; rst_b = 1'b1;
    req = 2'b00; req_rw = 2'b00; req_wdata0 = '0; req_wdata1 = '0; intr_in = 1'b0;
    model_rr = 1'b0; model_rdata = '0; s_data = '0; s_irq = '0;
    repeat (3) @(negedge clk);
    chk("reset_bus", 32'({sclk_m, cs_m, mosi_m, gnt_m, done_m, busy_m, irq_valid_m}), 32'd0);
    chk("reset_regs", 32'({irq_addr_m, rdata_m}), 32'd0);
    rst_a = 1'b0;
    @(negedge clk);

    frame(2'b01, 2'b01, 8'h5A, 8'h00, 8'h00, 1'b0);
    frame(2'b10, 2'b00, 8'h00, 8'h00, 8'hAB, 1'b0);
    frame(2'b01, 2'b01, 8'h33, 8'h00, 8'h77, 1'b0);
    frame(2'b10, 2'b00, 8'h00, 8'h00, 8'($urandom), 1'b0);

    // Both requesting continuously: grants must alternate.
    for (int i = 0; i < 4; i++)
      frame(2'b11, 2'b10, 8'($urandom), 8'($urandom), 8'($urandom), i < 3);

    req_rw = 2'b01; req_wdata0 = 8'hC3;
    irq(8'h51, 1'b1, 2'b01);
    frame(2'b01, 2'b01, 8'hC3, 8'h00, 8'h00, 1'b0);

    fork
      frame(2'b01, 2'b00, 8'h00, 8'h00, 8'hE7, 1'b0);
      begin
        repeat (30) @(negedge clk);
        intr_in = 1'b1;
      end
    join
    irq(8'h3C, 1'b0, 2'b00);

    // Reset in the middle of DATA bit 3 with sclk high.
    wr = 8'($urandom) | 8'h08;
    req = 2'b01; req_rw = 2'b01; req_wdata0 = wr;
    #1;
    chk("rst_gnt", 32'(gnt_m), 32'd1);
    model_rr = 1'b1;
    @(negedge clk);
    req = 2'b00;
    repeat (11 * cd) @(negedge clk);
    chk("rst_pre", 32'({cs_m, sclk_m, mosi_m, busy_m}), 32'hF);
    #2 rst_a = 1'b1;
    #1;
    chk("rst_async", 32'({cs_m, sclk_m, mosi_m, busy_m, done_m, gnt_m}), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'({done_m, busy_m, rdata_m}), 32'd0);
    rst_a = 1'b0;
    model_rr = 1'b0; model_rdata = '0;
    @(negedge clk);
    frame(2'b11, 2'b11, 8'($urandom), 8'($urandom), 8'h00, 1'b0);

    for (int i = 0; i < 6; i++)
      frame(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 1'b0);

    rst_a = 1'b1;
    sel = 1'b1; cd = 2;
    model_rr = 1'b0; model_rdata = '0;
    @(negedge clk);
    chk("reset_b", 32'({sclk_m, cs_m, mosi_m, gnt_m, done_m, busy_m, rdata_m}), 32'd0);
    rst_b = 1'b0;
    @(negedge clk);
    frame(2'b01, 2'b01, 8'hFF, 8'h00, 8'h00, 1'b0);
    frame(2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    frame(2'b10, 2'b00, 8'h00, 8'h00, 8'($urandom), 1'b0);
    frame(2'b01, 2'b01, 8'($urandom), 8'h00, 8'h00, 1'b0);
    irq(8'($urandom), 1'b1, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
